// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-cycle expiry pulse.
// Optional auto-reload turns it into a periodic tick source.
module down_counter_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             d_en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      d_out_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_out_q  <= d_out_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    d_out_d  = d_out_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      d_out_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (d_en) begin
            if (d_out_q == ONE) begin
              // terminal count: pulse, then reload or stop
              done_d = 1'b1;
              if (auto_reload) begin
                d_out_d = reload_q;
              end else begin
                d_out_d = '0;
                state_d = IDLE;
              end
            end else begin
              d_out_d = d_out_q - ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d_out = d_out_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign zero  = (d_out_q == '0);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counting timer: the counterpart of the free-running up counter used in the func-test circuits. It counts a preset value down to zero and flags expiry. Software or upstream logic loads a 12-bit period, gates counting with an enable, and gets a one-cycle done pulse at terminal count. An optional auto-reload mode makes it a periodic tick generator. It sits beside the up counter as the timing or stimulus source in the same test circuits.

Parameters:
WIDTH, 12, counter and load-value width in bits (WIDTH >= 2).

Ports:
clock  input  1  rising-edge clock; the only clock
rst  input  1  synchronous reset, active-high
load  input  1  load load_val into the counter and reload register
load_val  input  WIDTH  period value to load
d_en  input  1  count enable; decrement by 1 when high and running
auto_reload  input  1  at terminal count: 1 = reload and keep running, 0 = stop
d_out  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN state (registered state decode)
done  output  1  one-cycle pulse on expiry (registered)
zero  output  1  combinational, (d_out == 0)

Behaviour:
- Storage: d_out register, reload_reg (WIDTH), state {IDLE, RUN}, done register.
- Reset (rst=1 at a rising edge) has the highest priority. It sets d_out=0, reload_reg=0, state=IDLE, done=0. Therefore busy=0 and zero=1.
- A reset mid-RUN aborts at once. No done pulse is produced.
- Priority order at each edge: rst > load > count.
- load=1 (any state):
  - d_out <= load_val and reload_reg <= load_val.
  - If load_val != 0, state <= RUN. If load_val == 0, state <= IDLE.
  - done <= 0.
  - A decrement in the same cycle is discarded.
- RUN, d_en=0: d_out, state and reload_reg hold. done <= 0.
- RUN, d_en=1, d_out > 1: d_out <= d_out - 1. done <= 0.
- RUN, d_en=1, d_out == 1 (terminal decrement):
  - done <= 1 for exactly one cycle.
  - If auto_reload=1: d_out <= reload_reg and state stays RUN.
  - If auto_reload=0: d_out <= 0 and state <= IDLE.
  - auto_reload is sampled only on this edge.
- IDLE: d_en is ignored, d_out holds, done <= 0.
- Latency:
  - d_out changes on the edge where the qualifying input is sampled.
  - done is high during the cycle immediately after the terminal-decrement edge.
- Count length: a period N (N >= 1) expires after exactly N enabled RUN cycles. With auto_reload=1, done pulses once every N enabled cycles.
- N=1 with auto_reload: done is high on every cycle following an enabled edge. d_out stays 1.
- No wrap-around: d_out never decrements below 0. RUN with d_out == 0 is unreachable.
- load on the same edge as the terminal decrement: load wins, and done is not pulsed.
- reload_reg changes only on load or rst. It is not modified by counting.
- Max value: load_val = 2^WIDTH-1 (4095) counts the full range with no overflow.

Test Plan:
- Reset: hold rst 2 cycles with load=1, load_val=5 -> d_out=0, busy=0, done=0, zero=1.
- One-shot:
  - Stimulus: load 3, then d_en=1 and auto_reload=0.
  - d_out sequence: 3,2,1,0.
  - done high for 1 cycle, when d_out first reads 0.
  - busy falls in that same cycle and d_out stays 0.
- Gapped enable: load 4, d_en pattern 1,0,0,1,1,1 -> d_out 4,3,3,3,2,1,0; done pulses only after the last enabled edge.
- Auto-reload:
  - Stimulus: load 2, d_en=1, auto_reload=1 for 7 cycles.
  - d_out sequence: 2,1,2,1,2,1,2.
  - done pulses 3 times, 2 cycles apart; busy stays 1.
- Load collision and zero load:
  - At d_out=1 with d_en=1, assert load with load_val=6 -> d_out=6, no done.
  - Then load 0 -> busy=0, zero=1, and d_en has no effect.
- Reset mid-run: load 4095, count 10 cycles (d_out=4085), assert rst -> d_out=0 next cycle, done never asserted, reload_reg=0 (a later run with auto_reload=1 is not started without a load).
